// File: rtl/input_port_ctrl.sv
// Input port controller: buffers flits, resolves the packet's output port
// through routing_module, requests it from the allocator and streams the
// packet (wormhole) until its tail.
`timescale 1ns/1ps
module input_port_ctrl #(
    parameter int DATA_SIZE  = 32,
    parameter int ADDR_SIZE  = 4,
    parameter int PORTS_NUM  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_SIZE+1:0]   in_flit,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [ADDR_SIZE-1:0]   dest_sw,
    input  logic [3:0]             port_num,
    output logic                   req_valid,
    output logic [3:0]             req_port,
    input  logic                   grant,
    output logic [DATA_SIZE+1:0]   out_flit,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   drop_err
);

    localparam int FW    = DATA_SIZE + 2;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, ROUTE, REQ, XFER, DROP} state_t;

    logic [FW-1:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 rdy_q;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 fire;
    logic [FW-1:0]        front;

    state_t               state;
    logic [FW-1:0]        hdr_flit;
    logic                 hdr_pending;
    logic [ADDR_SIZE-1:0] dest_reg;
    logic [3:0]           port_reg;
    logic                 req_valid_q;
    logic                 drop_q;

    // rdy_q keeps in_ready low while in reset and for the release edge
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = rdy_q && !full;
    assign push      = in_valid && in_ready;
    assign front     = mem[rd_ptr];
    assign dest_sw   = dest_reg;
    assign req_valid = req_valid_q;
    assign req_port  = port_reg;
    assign drop_err  = drop_q;

    // Output path and FIFO pop decision for the current state
    always_comb begin
        out_valid = (state == XFER) && (hdr_pending || !empty);
        out_flit  = hdr_pending ? hdr_flit : front;
        fire      = out_valid && out_ready;
        pop       = 1'b0;
        case (state)
            IDLE:    pop = !empty;
            XFER:    pop = fire && !hdr_pending;
            DROP:    pop = !empty && !hdr_flit[FW-1];
            default: pop = 1'b0;
        endcase
    end

    // FIFO storage (no reset needed, validity tracked by count)
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_flit;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
        end
    end

    // Packet FSM: header capture, routing, request, transfer, discard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            hdr_flit    <= '0;
            hdr_pending <= 1'b0;
            dest_reg    <= '0;
            port_reg    <= '0;
            req_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        if (front[FW-2]) begin
                            hdr_flit    <= front;
                            hdr_pending <= 1'b1;
                            dest_reg    <= front[ADDR_SIZE-1:0];
                            state       <= ROUTE;
                        end else begin
                            drop_q <= 1'b1;
                        end
                    end
                end
                ROUTE: begin
                    port_reg <= port_num;
                    if (int'(port_num) >= PORTS_NUM) begin
                        drop_q      <= 1'b1;
                        hdr_pending <= 1'b0;
                        state       <= DROP;
                    end else begin
                        req_valid_q <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (grant) state <= XFER;
                end
                XFER: begin
                    if (fire) begin
                        hdr_pending <= 1'b0;
                        // tail or single flit closes the packet
                        if (out_flit[FW-1]) begin
                            req_valid_q <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (hdr_flit[FW-1])
                        state <= IDLE;
                    else if (!empty && front[FW-1])
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_input_port_ctrl.sv
// Scoreboard bench for input_port_ctrl: expected flits are queued when
// driven and compared by a monitor when the DUT transfers them.
`timescale 1ns/1ps
module tb_input_port_ctrl;

    localparam int FW = 34;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] in_flit;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    dest_sw;
    logic [3:0]    port_num;
    logic          req_valid;
    logic [3:0]    req_port;
    logic          grant;
    logic [FW-1:0] out_flit;
    logic          out_valid;
    logic          out_ready;
    logic          drop_err;

    input_port_ctrl #(
        .DATA_SIZE(32), .ADDR_SIZE(4), .PORTS_NUM(4), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid),
        .in_ready(in_ready), .dest_sw(dest_sw), .port_num(port_num),
        .req_valid(req_valid), .req_port(req_port), .grant(grant),
        .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
        .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    // Combinational routing model
    logic [3:0] route_map [16];
    always_comb port_num = route_map[dest_sw];

    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            drop_cnt = 0;
    logic [FW-1:0] sb [$];
    logic [3:0]    req_log [$];
    int            req_rise_cyc [$];
    int            tail_cycs [$];
    logic          req_prev = 1'b0;
    logic          chk_req_drop = 1'b0;
    logic [FW-1:0] want;

    always @(posedge clk) cyc++;

    // Monitor: sampled at the falling edge, away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            req_prev     = 1'b0;
            chk_req_drop = 1'b0;
        end else begin
            if (chk_req_drop) begin
                tests++;
                if (req_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL req_drop_after_tail: req_valid=%b required 0", req_valid);
                end
                chk_req_drop = 1'b0;
            end
            if (drop_err === 1'b1) drop_cnt++;
            if (req_valid === 1'b1 && !req_prev) begin
                req_log.push_back(req_port);
                req_rise_cyc.push_back(cyc);
            end
            req_prev = req_valid;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL xfer_unexpected: got %h, required no transfer", out_flit);
                end else begin
                    want = sb.pop_front();
                    if (out_flit !== want) begin
                        fails++;
                        $display("FAIL xfer_data: got %h required %h", out_flit, want);
                    end
                end
                tests++;
                if (req_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL req_lock: req_valid=%b required 1 during transfer", req_valid);
                end
                if (out_flit[FW-1]) begin
                    chk_req_drop = 1'b1;
                    tail_cycs.push_back(cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] t, input logic [31:0] d, input bit sb_push);
        in_flit  = {t, d};
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (in_ready === 1'b1) begin
                if (sb_push) sb.push_back(in_flit);
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        tests++;
        fails++;
        $display("FAIL send_timeout: in_ready=%b required 1 within 200 cycles", in_ready);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input bit toggle);
        grant     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (toggle) out_ready = ~out_ready;
            if (sb.size() == 0 && req_valid === 1'b0 && out_valid === 1'b0) return;
        end
        tests++;
        fails++;
        $display("FAIL drain_timeout: %0d flits pending, required 0", sb.size());
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_flit = '0; out_ready = 1'b0; grant = 1'b0;
        #12;
        tests++;
        if ({in_ready, req_valid, out_valid, drop_err, dest_sw, req_port} !== 12'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {in_ready, req_valid, out_valid, drop_err, dest_sw, req_port});
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_single();
        logic [FW-1:0] f;
        f = {2'b11, 32'hA5A5_0005};
        grant = 1'b1; out_ready = 1'b1;
        send(2'b11, 32'hA5A5_0005, 1'b1);
        tick();
        tests++;
        if (dest_sw !== 4'd5) begin
            fails++; $display("FAIL single_dest_sw: got %0d required 5", dest_sw);
        end
        tick();
        tests++;
        if (req_valid !== 1'b1) begin
            fails++; $display("FAIL single_req_valid: got %b required 1", req_valid);
        end
        tests++;
        if (req_port !== 4'd2) begin
            fails++; $display("FAIL single_req_port: got %0d required 2", req_port);
        end
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_flit !== f) begin
            fails++;
            $display("FAIL single_out: valid=%b flit=%h required 1/%h", out_valid, out_flit, f);
        end
        tick();
        tick();
        tests++;
        if (req_valid !== 1'b0) begin
            fails++; $display("FAIL single_req_release: got %b required 0", req_valid);
        end
    endtask

    task automatic test_packet();
        int n0;
        bit bad;
        n0 = req_log.size();
        grant = 1'b0; out_ready = 1'b1;
        send(2'b01, 32'h0000_0003, 1'b1);
        send(2'b00, 32'h1111_1111, 1'b1);
        send(2'b00, 32'h2222_2222, 1'b1);
        send(2'b10, 32'h3333_3333, 1'b1);
        send(2'b11, 32'h0000_0007, 1'b1);
        tests++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL packet_full: in_ready=%b required 0", in_ready);
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (req_valid !== 1'b1 || out_valid !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++; $display("FAIL packet_hold_req: req_valid=%b out_valid=%b required 1/0", req_valid, out_valid);
        end
        tests++;
        if (req_log.size() <= n0 || req_log[n0] !== 4'd3) begin
            fails++; $display("FAIL packet_req_port: got %0d entries required port 3", req_log.size() - n0);
        end
        wait_drain(100, 1'b1);
        tests++;
        if (req_log.size() != n0 + 2 || req_log[n0 + 1] !== 4'd1) begin
            fails++; $display("FAIL packet_next_req: got %0d requests required 2", req_log.size() - n0);
        end
    endtask

    task automatic test_invalid();
        int d0, n0;
        d0 = drop_cnt; n0 = req_log.size();
        grant = 1'b1; out_ready = 1'b1;
        send(2'b01, 32'h0000_0009, 1'b0);
        send(2'b00, 32'h4444_4444, 1'b0);
        send(2'b10, 32'h5555_5555, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        tests++;
        if (drop_cnt - d0 != 1) begin
            fails++; $display("FAIL invalid_drop_err: got %0d pulses required 1", drop_cnt - d0);
        end
        tests++;
        if (req_log.size() != n0) begin
            fails++; $display("FAIL invalid_no_req: got %0d requests required 0", req_log.size() - n0);
        end
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL invalid_idle: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_stray();
        int d0, n0;
        d0 = drop_cnt; n0 = req_log.size();
        send(2'b00, 32'h6666_6666, 1'b0);
        send(2'b10, 32'h7777_7777, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        tests++;
        if (drop_cnt - d0 != 2) begin
            fails++; $display("FAIL stray_drop_err: got %0d pulses required 2", drop_cnt - d0);
        end
        send(2'b11, 32'hBEEF_0001, 1'b1);
        wait_drain(50, 1'b0);
        tests++;
        if (req_log.size() != n0 + 1 || req_log[n0] !== 4'd1) begin
            fails++; $display("FAIL stray_then_head: got %0d requests required 1 to port 1", req_log.size() - n0);
        end
    endtask

    task automatic test_back_to_back();
        int n0, m0;
        n0 = req_log.size(); m0 = tail_cycs.size();
        grant = 1'b1; out_ready = 1'b1;
        send(2'b11, 32'hC0DE_0001, 1'b1);
        send(2'b11, 32'hC0DE_0002, 1'b1);
        wait_drain(60, 1'b0);
        tests++;
        if (req_log.size() != n0 + 2 || req_log[n0] !== 4'd1 || req_log[n0 + 1] !== 4'd0) begin
            fails++; $display("FAIL b2b_req_ports: got %0d requests required ports 1 then 0", req_log.size() - n0);
        end else begin
            tests++;
            if (tail_cycs.size() <= m0 || req_rise_cyc[n0 + 1] <= tail_cycs[m0]) begin
                fails++; $display("FAIL b2b_req_order: second req cycle %0d required after first tail", req_rise_cyc[n0 + 1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        grant = 1'b1; out_ready = 1'b0;
        send(2'b01, 32'hD000_0003, 1'b1);
        send(2'b00, 32'hD111_1111, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        tests++;
        if (out_valid !== 1'b1) begin
            fails++; $display("FAIL midreset_setup: out_valid=%b required 1", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (req_valid !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL midreset_async: req=%b out=%b rdy=%b required 0/0/0", req_valid, out_valid, in_ready);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || req_valid !== 1'b0) begin
            fails++;
            $display("FAIL midreset_empty: rdy=%b out=%b req=%b required 1/0/0", in_ready, out_valid, req_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) route_map[i] = 4'(i % 4);
        route_map[5] = 4'd2;
        route_map[9] = 4'd4;
        route_map[2] = 4'd0;
        route_map[7] = 4'd1;
        test_reset();
        test_single();
        test_packet();
        test_invalid();
        test_stray();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/input_port_ctrl.md
Name: input_port_ctrl

Overview:
- Per-input-port controller of the NoC switch, sitting directly upstream of routing_module.
- Buffers incoming flits in a small FIFO and decodes the destination from each head flit, which it drives to routing_module as dest_sw.
- Registers the returned port_num and requests that output port from the switch allocator.
- Holds the request for the whole packet (wormhole) and streams flits out until the tail.

Parameters:
- DATA_SIZE, 32, flit payload width; the full flit is DATA_SIZE+2 bits.
- ADDR_SIZE, 4, switch address width; must match routing_module.
- PORTS_NUM, 4, number of valid output port indices (0..PORTS_NUM-1).
- FIFO_DEPTH, 4, input buffer depth in flits; power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_flit  in  DATA_SIZE+2  incoming flit. Bits [DATA_SIZE+1:DATA_SIZE] are the type: 00 body, 01 head, 10 tail, 11 single (head+tail). A head or single flit carries its destination in [ADDR_SIZE-1:0].
- in_valid  in  1  in_flit valid.
- in_ready  out  1  FIFO can accept a flit.
- dest_sw  out  ADDR_SIZE  destination to routing_module (latched head destination).
- port_num  in  4  output port index returned by routing_module.
- req_valid  out  1  output-port request to the allocator.
- req_port  out  4  requested output port index.
- grant  in  1  allocator grant for req_port.
- out_flit  out  DATA_SIZE+2  FIFO front flit, type bits unchanged.
- out_valid  out  1  out_flit valid toward the crossbar.
- out_ready  in  1  downstream accepts out_flit.
- drop_err  out  1  one-cycle pulse on a discarded flit or packet.

Behaviour:
- Reset:
  - rst asynchronous, active-high.
  - While asserted: FIFO empty, state IDLE, dest_sw=0, req_port=0; req_valid, out_valid, drop_err, in_ready all 0.
  - First edge after release: in_ready=1.
  - Reset mid-packet discards all buffered flits; no partial-packet recovery.
- FIFO:
  - Push when in_valid && in_ready; in_ready = !full.
  - No same-cycle bypass when full: a pop frees space visible on the next cycle.
  - Pointers wrap modulo FIFO_DEPTH; occupancy count is clog2(FIFO_DEPTH)+1 bits.
- FSM, registered states:
  - IDLE:
    - FIFO empty: stay.
    - Front flit is head/single: latch dest_reg <= front[ADDR_SIZE-1:0] and pop it into the header stage; go to ROUTE.
    - Front flit is body/tail: pop it, pulse drop_err, stay in IDLE.
  - ROUTE:
    - dest_sw = dest_reg during this state; latch port_reg <= port_num (routing_module is combinational).
    - port_num >= PORTS_NUM: go to DROP and pulse drop_err.
    - Otherwise go to REQ.
  - REQ:
    - Assert req_valid=1, req_port=port_reg.
    - On grant go to XFER; otherwise hold request unchanged.
  - XFER:
    - req_valid stays 1 (lock).
    - First out_flit is the latched header flit; afterwards the FIFO front.
    - out_valid = header pending || FIFO non-empty.
    - Transfer occurs on out_valid && out_ready.
    - Transfer of a tail or single flit: next state IDLE, and req_valid drops on the following cycle.
    - grant is ignored once in XFER.
  - DROP:
    - Pop the FIFO front each cycle it is non-empty, without output.
    - The latched header is discarded.
    - Return to IDLE after popping a tail (or immediately if the header was single).
- Latency:
  - Head pushed at edge N → IDLE sees it in cycle N+1 → ROUTE N+2 → req_valid in N+3.
  - With grant in N+3: out_valid asserted in N+4 with the head flit.
- Simultaneous events:
  - Push and pop in the same cycle keep occupancy constant.
  - A head/single arriving while in XFER/DROP is only examined after returning to IDLE.
- Packet-format violations:
  - A head seen mid-packet in XFER is forwarded as data; packet boundaries are defined only by tail/single flits.
- dest_sw holds its last value outside ROUTE.

Test Plan:
- Reset checks:
  - Reset asserted → all outputs 0.
  - Reset released → in_ready=1 after one edge.
  - Reset pulsed mid-XFER → req_valid=0 and out_valid=0 immediately; FIFO empty.
- Single flit, type 11, dest 5:
  - Stimulus: routing returns port_num 2; grant held high.
  - Required: dest_sw=5 in ROUTE, req_port=2 at N+3, out_flit equals input at N+4, req_valid low at N+6.
- 4-flit packet (head dest 3, 2 bodies, tail) with FIFO_DEPTH=4:
  - Stimulus: grant delayed 5 cycles; out_ready toggling.
  - Required: in_ready falls when full; flits emerge in order, none duplicated or lost; req_valid stays high until the cycle after the tail transfer.
- Invalid port:
  - Stimulus: routing returns port_num 4 (PORTS_NUM=4) for a 3-flit packet.
  - Required: drop_err pulses once, req_valid never asserted, FIFO empty after the tail, IDLE.
- Stray flits:
  - Stimulus: body flit, then tail flit, arriving in IDLE.
  - Required: each dropped with its own drop_err pulse; a following valid head is routed normally.
- Back-to-back packets:
  - Stimulus: two single flits to ports 1 and 0.
  - Required: second request issued only after the first packet's tail transfer; req_port 1 then 0.
